regfile_port_arbiter: RTL
=========================

Name: regfile_port_arbiter

Overview:
- Shares the single access port of the 32x32 register file between two requesters, A (fetch/decode side) and B (debug/load side).
- Round-robin arbitration with req/gnt handshake.
- Sequences each granted operation onto the regfile write controls or read-mux address, and returns read data with a valid pulse.
- Sits between the requesters and the regfile plus its 32:1 read mux.

Parameters:
- AW, 5, regfile address width (32 entries).
- DW, 32, data width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- a_req  input  1  requester A access request.
- a_we  input  1  A: 1=write, 0=read.
- a_addr  input  AW  A register address.
- a_wdata  input  DW  A write data.
- a_gnt  output  1  A granted, one-cycle pulse.
- a_rvalid  output  1  A read data valid, one-cycle pulse.
- a_rdata  output  DW  A read data, held until next A read completes.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B.
- rf_we  output  1  regfile write enable.
- rf_addr  output  AW  shared regfile address (write address and read-mux select).
- rf_wdata  output  DW  regfile write data.
- rf_rdata  input  DW  read-mux output; combinational from rf_addr, same cycle.

Behaviour:
- FSM states:
  - IDLE: no operation in flight.
  - SERVE: one cycle, operation driven on rf_*.
- Arbitration at each rising edge, in state IDLE or SERVE:
  - Eligible set is {A if a_req} ∪ {B if b_req}.
  - In SERVE, the requester currently granted is excluded.
  - Both eligible: the one not granted last wins. last_grant resets to B, so A wins the first tie.
  - Winner present: next state SERVE, winner's we/addr/wdata captured into op registers, last_grant updated.
  - No winner: next state IDLE.
- SERVE cycle outputs:
  - Winner's gnt=1.
  - rf_addr = captured addr.
  - Write: rf_we=1, rf_wdata = captured wdata.
  - Read: rf_we=0; rf_rdata sampled at the end of SERVE into that requester's rdata register, and its rvalid=1 in the next cycle.
- Latency from req seen in IDLE:
  - gnt: +1 cycle.
  - Write commit: end of the gnt cycle.
  - rvalid: +2 cycles.
- Throughput:
  - Alternating A/B requests: one operation per cycle.
  - A single requester: at most one operation per 2 cycles.
- Handshake rules:
  - Requester holds req/we/addr/wdata stable until it sees gnt.
  - In the gnt cycle it may present a new request, which is ignored until the next edge.
  - Dropping req before gnt withdraws the request; no operation is performed.
  - Inputs changing after the capture edge do not affect the operation in flight.
- Write then read of the same address, back-to-back (B write, next cycle A read): the read returns the new value. The regfile write is synchronous, so no bypass is needed.
- Simultaneous read and write requests to the same address: arbitration order decides. The loser sees the post-winner state.
- rvalid and gnt for different requesters may be high in the same cycle.
- Outside SERVE: rf_we=0; rf_addr and rf_wdata hold their last values.
- Reset (any cycle, including mid-SERVE or with rvalid pending):
  - state=IDLE, last_grant=B.
  - All gnt/rvalid/rf_we = 0; a_rdata, b_rdata, rf_addr, rf_wdata = 0.
  - Pending rvalid is discarded; an in-flight write is not committed if rst_n is low at that edge.

Optional Feature:
- Macro: REGFILE_ARB_R0_ZERO_EN.
- Defined:
  - Address 0 is hardwired zero.
  - Write to addr 0: gnt still pulses, rf_we stays 0.
  - Read of addr 0: returns 0 regardless of rf_rdata.
- Undefined: address 0 is treated like any other register.

Decomposition:
- Shared package holds:
  - AW/DW defaults.
  - FSM state encoding (ST_IDLE=1'b0, ST_SERVE=1'b1).
  - Requester ID constants (REQ_A=1'b0, REQ_B=1'b1).
- One sub-module, rr_arb2: 2-way round-robin picker with exclude input and last_grant register, returning a winner-valid and winner-ID.
- Top level holds the FSM, op capture and read-data return.

Test Plan:
- Reset, then A write addr 3=0xDEADBEEF, then A read addr 3 -> a_gnt pulses 1 cycle after each req; rf_we=1 with rf_addr=3 in the write gnt cycle; a_rvalid 2 cycles after the read req with a_rdata=0xDEADBEEF.
- A and B both request continuously: A write 5=0x11, B read 5, then A again -> grants ordered A,B,A on consecutive cycles; b_rdata=0x00000011.
- A holds req continuously with no B -> a_gnt every other cycle, never two consecutive cycles.
- B asserts req then drops it before gnt while A is served -> no b_gnt, no rf_we for B, regfile unchanged.
- rst_n low during the SERVE of a read addr 7 -> no a_rvalid; after reset a_rdata=0 and the first A/B tie is granted to A.
- With REGFILE_ARB_R0_ZERO_EN defined, write addr 0=0xFFFFFFFF then read addr 0 -> gnt pulses, rf_we stays 0, rdata=0. Without the macro the read returns 0xFFFFFFFF.

Source files
------------

// File: rtl/regfile_port_arbiter_pkg.sv
// Shared types and defaults for the two-requester regfile port arbiter.
// FSM encoding and requester IDs live here so the top and the picker agree.
package regfile_port_arbiter_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

endpackage

// File: rtl/regfile_port_arbiter_rr_arb2.sv
// Two-way round-robin picker; combinational winner, last_grant updated on every win.
// Latency 0 (pick) / 1 (history); the excluded requester is skipped for this pick only.
module rr_arb2
    import regfile_port_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_req_a,
    input  logic    i_req_b,
    input  logic    i_excl_vld,
    input  req_id_t i_excl_id,
    output logic    o_win_vld,
    output req_id_t o_win_id
);

    req_id_t r_last;
    logic    w_elig_a;
    logic    w_elig_b;

    assign w_elig_a = i_req_a && !(i_excl_vld && (i_excl_id == REQ_A));
    assign w_elig_b = i_req_b && !(i_excl_vld && (i_excl_id == REQ_B));

    always_comb begin
        o_win_vld = w_elig_a || w_elig_b;
        o_win_id  = REQ_A;
        if (w_elig_a && w_elig_b) begin
            // Tie goes to whoever did not win last time.
            if (r_last == REQ_A) begin
                o_win_id = REQ_B;
            end else begin
                o_win_id = REQ_A;
            end
        end else if (w_elig_b) begin
            o_win_id = REQ_B;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= REQ_B;
        end else if (o_win_vld) begin
            r_last <= o_win_id;
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares one regfile access port between requesters A and B (round-robin, one op per SERVE cycle).
// gnt 1 cycle after req, rvalid 2 cycles; optional REGFILE_ARB_R0_ZERO_EN hardwires address 0 to zero.
module regfile_port_arbiter
    import regfile_port_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          rf_we,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_wdata,
    input  logic [DW-1:0] rf_rdata
);

    state_t        r_state;
    state_t        w_state_nxt;
    req_id_t       r_cur;
    logic          r_op_we;
    logic [AW-1:0] r_op_addr;
    logic [DW-1:0] r_op_wdata;
    logic          r_a_rvalid;
    logic          r_b_rvalid;
    logic [DW-1:0] r_a_rdata;
    logic [DW-1:0] r_b_rdata;

    logic          w_serve;
    logic          w_win_vld;
    req_id_t       w_win_id;
    logic          w_addr_r0;
    logic          w_rd_a;
    logic          w_rd_b;
    logic [DW-1:0] w_rd_dat;

    assign w_serve = (r_state == ST_SERVE);

    rr_arb2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req_a    (a_req),
        .i_req_b    (b_req),
        .i_excl_vld (w_serve),
        .i_excl_id  (r_cur),
        .o_win_vld  (w_win_vld),
        .o_win_id   (w_win_id)
    );

`ifdef REGFILE_ARB_R0_ZERO_EN
    assign w_addr_r0 = (r_op_addr == '0);
`else
    assign w_addr_r0 = 1'b0;
`endif

    assign w_rd_dat = w_addr_r0 ? '0 : rf_rdata;
    assign w_rd_a   = w_serve && !r_op_we && (r_cur == REQ_A);
    assign w_rd_b   = w_serve && !r_op_we && (r_cur == REQ_B);

    always_comb begin
        w_state_nxt = ST_IDLE;
        a_gnt       = 1'b0;
        b_gnt       = 1'b0;
        rf_we       = 1'b0;
        if (w_win_vld) begin
            w_state_nxt = ST_SERVE;
        end
        if (w_serve) begin
            a_gnt = (r_cur == REQ_A);
            b_gnt = (r_cur == REQ_B);
            // rst_n gating keeps a write from committing on the reset edge.
            rf_we = r_op_we && !w_addr_r0 && rst_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cur      <= REQ_B;
            r_op_we    <= 1'b0;
            r_op_addr  <= '0;
            r_op_wdata <= '0;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_win_vld) begin
                r_cur <= w_win_id;
                if (w_win_id == REQ_A) begin
                    r_op_we    <= a_we;
                    r_op_addr  <= a_addr;
                    r_op_wdata <= a_wdata;
                end else begin
                    r_op_we    <= b_we;
                    r_op_addr  <= b_addr;
                    r_op_wdata <= b_wdata;
                end
            end
            r_a_rvalid <= w_rd_a;
            r_b_rvalid <= w_rd_b;
            if (w_rd_a) begin
                r_a_rdata <= w_rd_dat;
            end
            if (w_rd_b) begin
                r_b_rdata <= w_rd_dat;
            end
        end
    end

    assign a_rvalid = r_a_rvalid;
    assign b_rvalid = r_b_rvalid;
    assign a_rdata  = r_a_rdata;
    assign b_rdata  = r_b_rdata;
    assign rf_addr  = r_op_addr;
    assign rf_wdata = r_op_wdata;

endmodule
